// File: rtl/axis_frame_arb.sv
// axis_frame_arb: 2:1 frame-granular AXI-Stream arbiter (PTP s0, TSS s1) with
// round-robin ties, oversize-frame truncation and a single registered output stage.
module axis_frame_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LEN    = 1472,
    parameter int LEN_W      = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tvalid,
    output logic                  s0_axis_tready,
    input  logic                  s0_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tvalid,
    output logic                  s1_axis_tready,
    input  logic                  s1_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic [1:0]            grant_o,
    output logic [15:0]           trunc_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS0 = 2'd1,
        PASS1 = 2'd2,
        DROP  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(MAX_LEN - 1);

    state_t                state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [15:0]           trunc_q, trunc_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic                  m_user_q, m_user_d;

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_last;
    logic                  in_ready;
    logic                  out_free;

    // Selected input follows the held grant; grant is 00 only in IDLE.
    always_comb begin
        in_data  = grant_q[1] ? s1_axis_tdata  : s0_axis_tdata;
        in_valid = grant_q[1] ? s1_axis_tvalid : s0_axis_tvalid;
        in_last  = grant_q[1] ? s1_axis_tlast  : s0_axis_tlast;
        out_free = !m_valid_q || m_axis_tready;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        trunc_d      = trunc_q;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        m_user_d     = m_user_q;
        in_ready     = 1'b0;

        if (m_axis_tready) begin
            m_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                // last_grant_q = 1 means s1 was served last, so s0 wins a tie
                if (s0_axis_tvalid && (!s1_axis_tvalid || last_grant_q)) begin
                    state_d      = PASS0;
                    grant_d      = 2'b01;
                    last_grant_d = 1'b0;
                end else if (s1_axis_tvalid) begin
                    state_d      = PASS1;
                    grant_d      = 2'b10;
                    last_grant_d = 1'b1;
                end
            end
            PASS0, PASS1: begin
                in_ready = out_free;
                if (in_valid && in_ready) begin
                    m_valid_d = 1'b1;
                    m_data_d  = in_data;
                    if (in_last) begin
                        m_last_d = 1'b1;
                        m_user_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = IDLE;
                        grant_d  = 2'b00;
                    end else if (cnt_q == LAST_IDX) begin
                        m_last_d = 1'b1;
                        m_user_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = DROP;
                        if (trunc_q != 16'hFFFF) begin
                            trunc_d = trunc_q + 16'd1;
                        end
                    end else begin
                        m_last_d = 1'b0;
                        m_user_d = 1'b0;
                        cnt_d    = cnt_q + 1'b1;
                    end
                end
            end
            DROP: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            trunc_q      <= '0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_user_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            trunc_q      <= trunc_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            m_user_q     <= m_user_d;
        end
    end

    assign s0_axis_tready = in_ready && grant_q[0];
    assign s1_axis_tready = in_ready && grant_q[1];
    assign m_axis_tdata   = m_data_q;
    assign m_axis_tvalid  = m_valid_q;
    assign m_axis_tlast   = m_last_q;
    assign m_axis_tuser   = m_user_q;
    assign grant_o        = grant_q;
    assign trunc_cnt_o    = trunc_q;

endmodule

// File: tb/tb_axis_frame_arb.sv
// tb_axis_frame_arb: table vectors, hand sequences and random traffic checked
// against a frame-level model of arbitration order and truncation.
module tb_axis_frame_arb;

    localparam int DW   = 8;
    localparam int MAXL = 8;
    localparam int LW   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s0_axis_tdata = '0;
    logic          s0_axis_tvalid = 1'b0;
    logic          s0_axis_tready;
    logic          s0_axis_tlast = 1'b0;
    logic [DW-1:0] s1_axis_tdata = '0;
    logic          s1_axis_tvalid = 1'b0;
    logic          s1_axis_tready;
    logic          s1_axis_tlast = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic [1:0]    grant_o;
    logic [15:0]   trunc_cnt_o;

    always #5 clk = ~clk;

    axis_frame_arb #(
        .DATA_WIDTH(DW),
        .MAX_LEN   (MAXL),
        .LEN_W     (LW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s0_axis_tdata (s0_axis_tdata),
        .s0_axis_tvalid(s0_axis_tvalid),
        .s0_axis_tready(s0_axis_tready),
        .s0_axis_tlast (s0_axis_tlast),
        .s1_axis_tdata (s1_axis_tdata),
        .s1_axis_tvalid(s1_axis_tvalid),
        .s1_axis_tready(s1_axis_tready),
        .s1_axis_tlast (s1_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .grant_o       (grant_o),
        .trunc_cnt_o   (trunc_cnt_o)
    );

    typedef struct {
        int          src;
        int          len;
        logic [7:0]  base;
        logic [7:0]  stp;
        int          stall;
        int          exp_n;
        bit          exp_user;
        logic [15:0] exp_trunc;
        logic [1:0]  exp_grant;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int gap_en = 0;
    int stall = 0;
    bit tog = 1'b0;

    logic [7:0] fr[$];
    logic [7:0] d0q[$], d1q[$];
    bit         l0q[$], l1q[$], f0q[$], f1q[$];
    logic [7:0] od[$], ed[$];
    bit         ol[$], ou[$], el[$], eu[$];
    int         oc[$], ic[$];
    logic [1:0] first_grant;
    bit         got_grant;
    bit         hold_chk = 1'b0;
    logic [7:0] hd;
    bit         hl, hu;

    task automatic chk(input bit ok, input string nm,
                       input longint act, input longint exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic make_fr(input int len, input logic [7:0] base,
                           input logic [7:0] stp);
        fr.delete();
        for (int i = 0; i < len; i++) fr.push_back(base + stp * 8'(i));
    endtask

    // Queue a frame on source s and append its expected output to the model.
    task automatic add_frame(input int s, input int len);
        int n;
        for (int i = 0; i < len; i++) begin
            if (s == 0) begin
                d0q.push_back(fr[i]);
                l0q.push_back(i == len - 1);
                f0q.push_back(i == 0);
            end else begin
                d1q.push_back(fr[i]);
                l1q.push_back(i == len - 1);
                f1q.push_back(i == 0);
            end
        end
        n = (len > MAXL) ? MAXL : len;
        for (int i = 0; i < n; i++) begin
            ed.push_back(fr[i]);
            el.push_back(i == n - 1);
            eu.push_back((i == n - 1) && (len > MAXL));
        end
    endtask

    task automatic clear_log();
        od.delete(); ol.delete(); ou.delete(); oc.delete(); ic.delete();
        ed.delete(); el.delete(); eu.delete();
        got_grant = 1'b0;
    endtask

    task automatic clear_src();
        d0q.delete(); l0q.delete(); f0q.delete();
        d1q.delete(); l1q.delete(); f1q.delete();
    endtask

    // One clock: drive at negedge, observe handshakes, cross the posedge.
    task automatic step();
        if (d0q.size() != 0) begin
            s0_axis_tvalid = f0q[0] ? 1'b1
                           : ((gap_en == 0) || ($urandom_range(0, 3) != 0));
            s0_axis_tdata  = d0q[0];
            s0_axis_tlast  = l0q[0];
        end else begin
            s0_axis_tvalid = 1'b0;
            s0_axis_tdata  = '0;
            s0_axis_tlast  = 1'b0;
        end
        if (d1q.size() != 0) begin
            s1_axis_tvalid = f1q[0] ? 1'b1
                           : ((gap_en == 0) || ($urandom_range(0, 3) != 0));
            s1_axis_tdata  = d1q[0];
            s1_axis_tlast  = l1q[0];
        end else begin
            s1_axis_tvalid = 1'b0;
            s1_axis_tdata  = '0;
            s1_axis_tlast  = 1'b0;
        end
        case (stall)
            0: m_axis_tready = 1'b1;
            1: begin
                m_axis_tready = tog;
                tog = ~tog;
            end
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (hold_chk) begin
            chk(m_axis_tvalid && m_axis_tdata == hd &&
                m_axis_tlast == hl && m_axis_tuser == hu,
                "stall_hold", {m_axis_tvalid, m_axis_tdata},
                {1'b1, hd});
        end
        hold_chk = m_axis_tvalid && !m_axis_tready;
        hd = m_axis_tdata;
        hl = m_axis_tlast;
        hu = m_axis_tuser;
        if (m_axis_tvalid && m_axis_tready) begin
            od.push_back(m_axis_tdata);
            ol.push_back(m_axis_tlast);
            ou.push_back(m_axis_tuser);
            oc.push_back(cyc);
        end
        chk(grant_o inside {2'b00, 2'b01, 2'b10}, "grant_onehot",
            grant_o, 0);
        if (s0_axis_tvalid && s0_axis_tready) begin
            ic.push_back(cyc);
            if (!got_grant) begin
                first_grant = grant_o;
                got_grant = 1'b1;
            end
            void'(d0q.pop_front());
            void'(l0q.pop_front());
            void'(f0q.pop_front());
        end
        if (s1_axis_tvalid && s1_axis_tready) begin
            ic.push_back(cyc);
            if (!got_grant) begin
                first_grant = grant_o;
                got_grant = 1'b1;
            end
            void'(d1q.pop_front());
            void'(l1q.pop_front());
            void'(f1q.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int maxc);
        int c = 0;
        while ((d0q.size() != 0 || d1q.size() != 0 || m_axis_tvalid) &&
               c < maxc) begin
            step();
            c++;
        end
        chk(c < maxc, "run_timeout", c, maxc);
        step();
        step();
    endtask

    task automatic check_out(input string nm);
        int n;
        n = (od.size() < ed.size()) ? od.size() : ed.size();
        chk(od.size() == ed.size(), {nm, " beats"}, od.size(), ed.size());
        for (int i = 0; i < n; i++) begin
            chk({od[i], ol[i], ou[i]} == {ed[i], el[i], eu[i]},
                $sformatf("%s beat%0d", nm, i),
                {od[i], ol[i], ou[i]}, {ed[i], el[i], eu[i]});
        end
    endtask

    function automatic logic [30:0] all_out();
        return {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata,
                s0_axis_tready, s1_axis_tready, grant_o, trunc_cnt_o};
    endfunction

    task automatic do_reset();
        s0_axis_tvalid = 1'b0;
        s1_axis_tvalid = 1'b0;
        m_axis_tready  = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        hold_chk = 1'b0;
        clear_src();
        chk(all_out() == '0, "reset_state", all_out(), 0);
    endtask

    vec_t tbl[6];
    int   ntr;
    int   len;

    initial begin
        tbl[0] = '{0, 4,  8'h11, 8'h11, 0, 4, 1'b0, 16'd0, 2'b01};
        tbl[1] = '{1, 6,  8'hA0, 8'h01, 1, 6, 1'b0, 16'd0, 2'b10};
        tbl[2] = '{0, 12, 8'h30, 8'h01, 0, 8, 1'b1, 16'd1, 2'b01};
        tbl[3] = '{0, 8,  8'h50, 8'h01, 0, 8, 1'b0, 16'd1, 2'b01};
        tbl[4] = '{1, 1,  8'h77, 8'h01, 2, 1, 1'b0, 16'd1, 2'b10};
        tbl[5] = '{1, 9,  8'h80, 8'h02, 2, 8, 1'b1, 16'd2, 2'b10};

        @(negedge clk);
        do_reset();

        for (int r = 0; r < 6; r++) begin
            clear_log();
            stall = tbl[r].stall;
            make_fr(tbl[r].len, tbl[r].base, tbl[r].stp);
            add_frame(tbl[r].src, tbl[r].len);
            run(300);
            check_out($sformatf("vec%0d", r));
            chk(od.size() == tbl[r].exp_n, $sformatf("vec%0d n", r),
                od.size(), tbl[r].exp_n);
            if (od.size() != 0) begin
                chk(ou[od.size()-1] == tbl[r].exp_user,
                    $sformatf("vec%0d user", r),
                    ou[od.size()-1], tbl[r].exp_user);
            end
            chk(trunc_cnt_o == tbl[r].exp_trunc,
                $sformatf("vec%0d trunc", r), trunc_cnt_o, tbl[r].exp_trunc);
            chk(got_grant && first_grant == tbl[r].exp_grant,
                $sformatf("vec%0d grant", r), first_grant, tbl[r].exp_grant);
            if (r == 0) begin
                for (int i = 0; i < 4; i++) begin
                    chk(oc.size() > i && ic.size() > i && oc[i] - ic[i] == 1,
                        $sformatf("latency%0d", i), oc[i] - ic[i], 1);
                end
            end
        end

        // Reset while beat 3 of a 5-beat frame is on the input.
        clear_log();
        stall = 0;
        make_fr(5, 8'hC0, 8'h01);
        add_frame(0, 5);
        for (int i = 0; i < 20 && ic.size() < 2; i++) step();
        chk(ic.size() == 2, "t5_reach_beat3", ic.size(), 2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        hold_chk = 1'b0;
        chk(all_out() == '0, "t5_reset_outputs", all_out(), 0);
        clear_src();
        clear_log();
        make_fr(4, 8'hE0, 8'h01);
        add_frame(1, 4);
        run(300);
        check_out("t5_after");
        chk(got_grant && first_grant == 2'b10, "t5_grant", first_grant, 2);

        // Tie after reset goes to s0; next tie (s1 waiting) goes to s1.
        do_reset();
        clear_log();
        make_fr(3, 8'h01, 8'h01);
        add_frame(0, 3);
        make_fr(3, 8'h81, 8'h01);
        add_frame(1, 3);
        make_fr(3, 8'h41, 8'h01);
        add_frame(0, 3);
        run(300);
        check_out("t2_tie");
        chk(oc.size() >= 4 && oc[3] - oc[2] == 2, "t2_bubble",
            oc[3] - oc[2], 2);

        // Continuous 3-beat frames on both inputs alternate strictly.
        do_reset();
        clear_log();
        for (int k = 0; k < 6; k++) begin
            make_fr(3, 8'(k * 16), 8'h01);
            add_frame(k % 2, 3);
        end
        run(300);
        check_out("t6_alt");

        // Random lengths, input gaps and output stalls; both inputs always
        // have a frame ready, so service alternates s0,s1,... from reset.
        for (int round = 0; round < 2; round++) begin
            do_reset();
            clear_log();
            gap_en = 1;
            stall = (round == 0) ? 2 : 0;
            ntr = 0;
            for (int k = 0; k < 32; k++) begin
                len = $urandom_range(1, 12);
                fr.delete();
                for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
                add_frame(k % 2, len);
                if (len > MAXL) ntr++;
            end
            run(5000);
            check_out($sformatf("rand%0d", round));
            chk(trunc_cnt_o == 16'(ntr), $sformatf("rand%0d trunc", round),
                trunc_cnt_o, ntr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
